dn_latch_nand: RTL and testbench

DN_LATCH_NAND -- requirements
Module: dn_latch_nand

---
 rtl/dn_latch_nand.sv | 41 ++++
 tb/tb_dn_latch_nand.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dn_latch_nand.sv
// D latch modelled as an edge-clocked hold register plus an output mux.
// Define DN_LATCH_NAND_REG_OUT_EN to drive Q from the register only (1-cycle latency).
module dn_latch_nand #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q
);

  logic [WIDTH-1:0] r_store;
  logic [WIDTH-1:0] w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store <= '0;
    end else if (En) begin
      r_store <= D;
    end
  end

`ifdef DN_LATCH_NAND_REG_OUT_EN
  // Output comes straight from the register: no D/En path to Q.
  assign w_q = r_store;
`else
  // Reset gating keeps Q at zero even while the mux is transparent.
  always_comb begin
    w_q = '0;
    if (rst_n) begin
      w_q = En ? D : r_store;
    end
  end
`endif

  assign Q     = w_q;
  assign not_Q = ~w_q;

endmodule

// File: tb/tb_dn_latch_nand.sv
// Directed vector bench for dn_latch_nand.
// Covers the registered-output build when DN_LATCH_NAND_REG_OUT_EN is defined.
`timescale 1ns/100ps
module tb_dn_latch_nand;

`ifdef DN_LATCH_NAND_REG_OUT_EN
  localparam int W = 8;
`else
  localparam int W = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         En = 1'b1;
  logic [W-1:0] D = '1;
  logic [W-1:0] Q;
  logic [W-1:0] not_Q;

  int n_chk = 0;
  int n_fail = 0;

  dn_latch_nand #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .En    (En),
    .D     (D),
    .Q     (Q),
    .not_Q (not_Q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] q;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input logic [W-1:0] exp, input string name);
    logic [W-1:0] nexp;
    nexp = ~exp;
    n_chk++;
    if (Q !== exp) begin
      n_fail++;
      $display("FAIL %s: Q=%h required %h at %0t", name, Q, exp, $time);
    end
    n_chk++;
    if (not_Q !== nexp) begin
      n_fail++;
      $display("FAIL %s: not_Q=%h required %h at %0t", name, not_Q, nexp, $time);
    end
  endtask

  task automatic setv(input logic r, input logic e, input logic [W-1:0] d);
    rst_n = r;
    En    = e;
    D     = d;
  endtask

  initial begin
`ifdef DN_LATCH_NAND_REG_OUT_EN
    #2 chk(8'h00, "reset");
    @(negedge clk);
    setv(1'b1, 1'b1, 8'hA5);
    #1 chk(8'h00, "before_edge");
    @(posedge clk);
    #1 chk(8'hA5, "after_edge");
    @(negedge clk);
    setv(1'b1, 1'b0, 8'h3C);
    #1 chk(8'hA5, "hold_pre");
    @(posedge clk);
    #1 chk(8'hA5, "hold_post");
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk(8'h00, "reset_async");
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk(8'h00, "reset_held");
`else
    // Each row: drive at negedge, check before the next posedge,
    // which then clocks the row's inputs into the store.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      setv(tbl[i].rst, tbl[i].en, tbl[i].d);
      #2 chk(tbl[i].q, $sformatf("vec%0d", i));
    end

    // Transparent follow within one clock period.
    @(negedge clk);
    setv(1'b1, 1'b1, 1'b0);
    #1 chk(1'b0, "follow0");
    D = 1'b1;
    #1 chk(1'b1, "follow1");
    D = 1'b0;
    #1 chk(1'b0, "follow2");

    // Hold zero across 50 ns of D=1.
    @(negedge clk);
    setv(1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    setv(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #2 chk(1'b0, $sformatf("hold_d1_%0d", i));
      @(negedge clk);
    end
    D = 1'b0;
    #2 chk(1'b0, "hold_d0");

    // Capture 1, hold it, then re-enable with D=0.
    @(negedge clk);
    setv(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    setv(1'b1, 1'b0, 1'b1);
    #2 chk(1'b1, "cap_hold_a");
    @(negedge clk);
    D = 1'b0;
    #2 chk(1'b1, "cap_hold_b");
    @(negedge clk);
    setv(1'b1, 1'b1, 1'b0);
    #2 chk(1'b0, "cap_reenable");

    // Short reset pulse in the middle of a hold of 1.
    @(negedge clk);
    setv(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    setv(1'b1, 1'b0, 1'b0);
    #1 chk(1'b1, "mid_pre");
    rst_n = 1'b0;
    #1 chk(1'b0, "mid_during");
    #2 rst_n = 1'b1;
    #0.5 chk(1'b0, "mid_release");
    @(negedge clk);
    #1 chk(1'b0, "mid_after");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
